// File: rtl/burgertime_pkg.sv
// Shared constants and types for the chef sprite pipeline.
package burgertime_pkg;

   localparam int unsigned SPR_W      = 16;
   localparam int unsigned SPR_H      = 16;
   localparam int unsigned H_ACTIVE   = 640;
   localparam int unsigned V_TOTAL    = 525;
   localparam int unsigned ROM_ADDR_W = 10;
   localparam int unsigned COORD_W    = 10;
   localparam int unsigned PIX_W      = 3;
   localparam int unsigned COL_W      = 4;

   typedef enum logic [1:0] {IDLE, CLEAR, ADDR, CAPTURE} fetch_state_t;

   typedef logic [1:0] anim_frame_t;

   // Walk cycle 1 -> 2 -> 3 -> 1; the idle frame 0 enters the cycle at 1.
   function automatic anim_frame_t next_anim(input anim_frame_t f);
      return (f == 2'd3) ? 2'd1 : anim_frame_t'(f + 2'd1);
   endfunction

endpackage

// File: rtl/chef_anim_ctrl.sv
// Per-frame latch of chef position/direction plus walk-animation divider.
// Macro CHEF_FLIP_EN enables latching of the facing direction.
module chef_anim_ctrl
   import burgertime_pkg::*;
#(
   parameter int unsigned ANIM_DIV = 8
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               frame_clk,
   input  logic [COORD_W-1:0] chef_x_in,
   input  logic [COORD_W-1:0] chef_y_in,
   input  logic               chef_moving,
   input  logic               chef_dir_left,
   output logic [COORD_W-1:0] chef_x,
   output logic [COORD_W-1:0] chef_y,
   output logic               dir_left,
   output anim_frame_t        anim_frame
);

   localparam int unsigned DIV_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

   logic             fc_q;
   logic             latch;
   logic             moving;
   logic [DIV_W-1:0] div_cnt;
   anim_frame_t      anim_q;

   assign latch      = frame_clk & ~fc_q;
   assign anim_frame = moving ? anim_q : anim_frame_t'(0);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         fc_q     <= 1'b0;
         chef_x   <= '0;
         chef_y   <= '0;
         moving   <= 1'b0;
         dir_left <= 1'b0;
         div_cnt  <= '0;
         anim_q   <= '0;
      end else begin
         fc_q <= frame_clk;
         if (latch) begin
            chef_x <= chef_x_in;
            chef_y <= chef_y_in;
            moving <= chef_moving;
`ifdef CHEF_FLIP_EN
            dir_left <= chef_dir_left;
`else
            // Direction is observed but forced low, so the mirror path folds away.
            dir_left <= chef_dir_left & 1'b0;
`endif
            if (!chef_moving) begin
               div_cnt <= '0;
               anim_q  <= '0;
            end else if (div_cnt == DIV_W'(ANIM_DIV - 1)) begin
               div_cnt <= '0;
               anim_q  <= next_anim(anim_q);
            end else begin
               div_cnt <= div_cnt + DIV_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/chef_sprite_engine.sv
// Chef sprite engine: hblank line fetch from sprite ROM and per-pixel lookup.
// Macro CHEF_FLIP_EN enables horizontal mirroring when the chef faces left.
module chef_sprite_engine
   import burgertime_pkg::*;
#(
   parameter int unsigned ANIM_DIV = 8,
   parameter int unsigned FETCH_X  = 640
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  frame_clk,
   input  logic [COORD_W-1:0]    DrawX,
   input  logic [COORD_W-1:0]    DrawY,
   input  logic [COORD_W-1:0]    chef_x_in,
   input  logic [COORD_W-1:0]    chef_y_in,
   input  logic                  chef_moving,
   input  logic                  chef_dir_left,
   output logic [ROM_ADDR_W-1:0] rom_addr,
   input  logic [PIX_W-1:0]      rom_data,
   output logic                  chef,
   output logic [PIX_W-1:0]      sprite_color_index
);

   logic [COORD_W-1:0] chef_x, chef_y;
   logic               dir_left;
   anim_frame_t        anim_frame;

   chef_anim_ctrl #(.ANIM_DIV(ANIM_DIV)) u_anim (
      .Clk           (Clk),
      .Reset         (Reset),
      .frame_clk     (frame_clk),
      .chef_x_in     (chef_x_in),
      .chef_y_in     (chef_y_in),
      .chef_moving   (chef_moving),
      .chef_dir_left (chef_dir_left),
      .chef_x        (chef_x),
      .chef_y        (chef_y),
      .dir_left      (dir_left),
      .anim_frame    (anim_frame)
   );

   logic [COORD_W-1:0] dx_q;
   logic               trig;
   logic [COORD_W-1:0] next_y, row;
   logic               in_sprite;

   // DrawX holds for two clocks per pixel; this history makes the trigger one pulse.
   always_ff @(posedge Clk) dx_q <= DrawX;

   assign trig      = (DrawX == COORD_W'(FETCH_X)) && (dx_q != COORD_W'(FETCH_X));
   assign next_y    = (DrawY == COORD_W'(V_TOTAL - 1)) ? '0 : DrawY + COORD_W'(1);
   assign row       = next_y - chef_y;
   assign in_sprite = ({1'b0, next_y} >= {1'b0, chef_y}) && ({1'b0, row} < 11'(SPR_H));

   fetch_state_t     state;
   logic [COL_W-1:0] col;
   logic [3:0]       row_q;
   logic [PIX_W-1:0] line_buf [SPR_W];

   // rom_addr is loaded on entry to ADDR so the ROM data is ready by CAPTURE.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state    <= IDLE;
         col      <= '0;
         row_q    <= '0;
         rom_addr <= '0;
         for (int i = 0; i < SPR_W; i++) line_buf[i] <= '0;
      end else begin
         case (state)
            IDLE: if (trig) begin
               if (in_sprite) begin
                  col      <= '0;
                  row_q    <= row[3:0];
                  rom_addr <= {anim_frame, row[3:0], COL_W'(0)};
                  state    <= ADDR;
               end else begin
                  state <= CLEAR;
               end
            end
            CLEAR: begin
               for (int i = 0; i < SPR_W; i++) line_buf[i] <= '0;
               state <= IDLE;
            end
            ADDR: state <= CAPTURE;
            CAPTURE: begin
               line_buf[col] <= rom_data;
               if (col == COL_W'(SPR_W - 1)) begin
                  state <= IDLE;
               end else begin
                  col      <= col + COL_W'(1);
                  rom_addr <= {anim_frame, row_q, col + COL_W'(1)};
                  state    <= ADDR;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   logic [10:0]      x_end;
   logic             hit;
   logic [COL_W-1:0] pcol, bcol;

   assign x_end = {1'b0, chef_x} + 11'(SPR_W);
   assign hit   = (DrawX < COORD_W'(H_ACTIVE)) && (DrawX >= chef_x) && ({1'b0, DrawX} < x_end);
   assign pcol  = COL_W'(DrawX - chef_x);
   // With a 16-wide sprite, SPR_W-1-col is the bitwise inverse of col.
   assign bcol  = pcol ^ {COL_W{dir_left}};

   assign sprite_color_index = hit ? line_buf[bcol] : '0;
   assign chef               = (sprite_color_index != '0);

endmodule

// File: tb/tb_chef_sprite_engine.sv
// Directed self-checking bench for chef_sprite_engine (honours CHEF_FLIP_EN).
module tb_chef_sprite_engine;
   import burgertime_pkg::*;

   logic       Clk = 1'b0;
   logic       Reset, frame_clk, chef_moving, chef_dir_left;
   logic [9:0] DrawX, DrawY, chef_x_in, chef_y_in;
   logic [9:0] rom_addr;
   logic [2:0] rom_data;
   logic       chef;
   logic [2:0] sprite_color_index;

   logic [2:0] rom [1024];
   int errors = 0;
   int checks = 0;

   chef_sprite_engine dut (
      .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .DrawX(DrawX), .DrawY(DrawY),
      .chef_x_in(chef_x_in), .chef_y_in(chef_y_in), .chef_moving(chef_moving),
      .chef_dir_left(chef_dir_left), .rom_addr(rom_addr), .rom_data(rom_data),
      .chef(chef), .sprite_color_index(sprite_color_index)
   );

   always #10 Clk = ~Clk;
   always @(posedge Clk) rom_data <= rom[rom_addr];

   task automatic tick(input int n);
      repeat (n) @(posedge Clk);
      #1;
   endtask

   task automatic vsync();
      frame_clk = 1'b1; tick(2);
      frame_clk = 1'b0; tick(2);
   endtask

   task automatic set_pos(input int x, input int y, input logic mv, input logic dl);
      chef_x_in = 10'(x); chef_y_in = 10'(y); chef_moving = mv; chef_dir_left = dl;
      vsync();
   endtask

   task automatic fetch_line(input int y);
      DrawY = 10'(y); DrawX = 10'd0; tick(2);
      DrawX = 10'd640; tick(34);
      DrawX = 10'd0; tick(1);
   endtask

   task automatic test_reset();
      Reset = 1'b1; DrawX = 10'd5; DrawY = 10'd0; tick(3);
      checks++; if (rom_addr !== 10'd0) begin errors++; $display("FAIL reset_rom_addr got=%0d exp=0", rom_addr); end
      checks++; if (sprite_color_index !== 3'd0) begin errors++; $display("FAIL reset_index got=%0d exp=0", sprite_color_index); end
      checks++; if (chef !== 1'b0) begin errors++; $display("FAIL reset_chef got=%b exp=0", chef); end
      Reset = 1'b0; tick(1);
   endtask

   task automatic test_fetch();
      logic [2:0] exp;
      set_pos(300, 100, 1'b0, 1'b0);
      DrawY = 10'd104; DrawX = 10'd639; tick(2);
      DrawX = 10'd640; tick(1);
      for (int c = 0; c < 16; c++) begin
         checks++;
         if (rom_addr !== 10'(80 + c)) begin errors++; $display("FAIL fetch_addr col=%0d got=%0d exp=%0d", c, rom_addr, 80 + c); end
         tick(2);
      end
      DrawY = 10'd105;
      for (int c = 0; c < 16; c++) begin
         DrawX = 10'(300 + c); tick(1);
         exp = 3'(c % 8);
         checks++;
         if (sprite_color_index !== exp || chef !== (exp != 3'd0)) begin
            errors++; $display("FAIL fetch_pixel col=%0d got=%0d/%b exp=%0d", c, sprite_color_index, chef, exp);
         end
      end
      DrawX = 10'd299; tick(1);
      checks++; if (chef !== 1'b0) begin errors++; $display("FAIL left_of_sprite got=%b exp=0", chef); end
      DrawX = 10'd316; tick(1);
      checks++; if (chef !== 1'b0) begin errors++; $display("FAIL right_of_sprite got=%b exp=0", chef); end
   endtask

   task automatic test_top_row();
      DrawY = 10'd99; DrawX = 10'd0; tick(2);
      DrawX = 10'd640; tick(1);
      checks++; if (rom_addr !== 10'd0) begin errors++; $display("FAIL top_row_addr got=%0d exp=0", rom_addr); end
      tick(33); DrawX = 10'd0; tick(1);
   endtask

   task automatic test_outside();
      int bad;
      DrawY = 10'd115; DrawX = 10'd0; tick(2);
      DrawX = 10'd640; tick(1);
      checks++; if (dut.state !== CLEAR) begin errors++; $display("FAIL below_edge_state got=%0d exp=%0d", dut.state, CLEAR); end
      DrawX = 10'd0; tick(2);
      DrawY = 10'd120; DrawX = 10'd640; tick(1);
      checks++; if (dut.state !== CLEAR) begin errors++; $display("FAIL outside_state got=%0d exp=%0d", dut.state, CLEAR); end
      tick(1);
      checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL outside_idle got=%0d exp=%0d", dut.state, IDLE); end
      DrawY = 10'd121; bad = 0;
      for (int c = 0; c < 16; c++) begin
         DrawX = 10'(300 + c); tick(1);
         if (sprite_color_index !== 3'd0 || chef !== 1'b0) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL outside_pixels nonzero=%0d exp=0", bad); end
   endtask

   task automatic test_clip();
      logic exp;
      set_pos(632, 100, 1'b0, 1'b0);
      fetch_line(108);
      for (int x = 632; x < 648; x++) begin
         DrawX = 10'(x); tick(1);
         exp = (x < 640);
         checks++;
         if (chef !== exp || sprite_color_index !== (exp ? 3'd5 : 3'd0)) begin
            errors++; $display("FAIL clip x=%0d got=%b/%0d exp=%b", x, chef, sprite_color_index, exp);
         end
      end
      DrawX = 10'd0; tick(40);
   endtask

   task automatic test_anim();
      logic [1:0] exp;
      chef_moving = 1'b1;
      for (int e = 1; e <= 24; e++) begin
         vsync();
         exp = (e < 8) ? 2'd0 : (e < 16) ? 2'd1 : (e < 24) ? 2'd2 : 2'd3;
         if (e == 7 || e == 8 || e == 15 || e == 16 || e == 24) begin
            checks++;
            if (dut.u_anim.anim_frame !== exp) begin errors++; $display("FAIL anim edge=%0d got=%0d exp=%0d", e, dut.u_anim.anim_frame, exp); end
         end
      end
      DrawY = 10'd104; DrawX = 10'd0; tick(2);
      DrawX = 10'd640; tick(1);
      checks++; if (rom_addr !== 10'd848) begin errors++; $display("FAIL anim_rom_addr got=%0d exp=848", rom_addr); end
      tick(33); DrawX = 10'd0; tick(1);
      chef_moving = 1'b0; vsync();
      checks++; if (dut.u_anim.anim_frame !== 2'd0) begin errors++; $display("FAIL anim_idle got=%0d exp=0", dut.u_anim.anim_frame); end
   endtask

   task automatic test_flip();
      logic [2:0] e0, e15;
`ifdef CHEF_FLIP_EN
      e0 = 3'b010; e15 = 3'b100;
`else
      e0 = 3'b100; e15 = 3'b010;
`endif
      set_pos(200, 100, 1'b0, 1'b1);
      fetch_line(106);
      DrawX = 10'd200; tick(1);
      checks++; if (sprite_color_index !== e0 || chef !== 1'b1) begin errors++; $display("FAIL flip_x200 got=%0d/%b exp=%0d", sprite_color_index, chef, e0); end
      DrawX = 10'd215; tick(1);
      checks++; if (sprite_color_index !== e15) begin errors++; $display("FAIL flip_x215 got=%0d exp=%0d", sprite_color_index, e15); end
      DrawX = 10'd207; tick(1);
      checks++; if (sprite_color_index !== 3'd3) begin errors++; $display("FAIL flip_x207 got=%0d exp=3", sprite_color_index); end
   endtask

   task automatic test_reset_mid_fetch();
      bit found = 0;
      int bad = 0;
      set_pos(300, 100, 1'b0, 1'b0);
      fetch_line(104);
      DrawY = 10'd104; DrawX = 10'd0; tick(2);
      DrawX = 10'd640;
      for (int k = 0; k < 40 && !found; k++) begin
         tick(1);
         if (rom_addr === 10'd87) found = 1;
      end
      checks++; if (!found) begin errors++; $display("FAIL mid_fetch_timeout got=%0d exp=87", rom_addr); end
      tick(1);
      checks++; if (dut.state !== CAPTURE) begin errors++; $display("FAIL mid_fetch_state got=%0d exp=%0d", dut.state, CAPTURE); end
      Reset = 1'b1; DrawX = 10'd1; tick(1);
      checks++; if (rom_addr !== 10'd0) begin errors++; $display("FAIL mid_reset_addr got=%0d exp=0", rom_addr); end
      checks++; if (sprite_color_index !== 3'd0 || chef !== 1'b0) begin errors++; $display("FAIL mid_reset_pixel got=%0d/%b exp=0", sprite_color_index, chef); end
      checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL mid_reset_state got=%0d exp=%0d", dut.state, IDLE); end
      Reset = 1'b0;
      for (int c = 0; c < 16; c++) begin
         DrawX = 10'(c); tick(1);
         if (sprite_color_index !== 3'd0 || rom_addr !== 10'd0) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL mid_reset_buffer nonzero=%0d exp=0", bad); end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) rom[i] = 3'd0;
      for (int c = 0; c < 16; c++) begin
         rom[c]            = 3'd6;
         rom[(5 << 4) | c] = 3'(c % 8);
         rom[(9 << 4) | c] = 3'd5;
         rom[(7 << 4) | c] = 3'd3;
      end
      rom[(7 << 4) | 0]  = 3'b100;
      rom[(7 << 4) | 15] = 3'b010;
      frame_clk = 1'b0; chef_moving = 1'b0; chef_dir_left = 1'b0;
      chef_x_in = '0; chef_y_in = '0; DrawX = '0; DrawY = '0; Reset = 1'b1;

      test_reset();
      test_fetch();
      test_top_row();
      test_outside();
      test_clip();
      test_anim();
      test_flip();
      test_reset_mid_fetch();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
